// File: rtl/key_event_ctrl.sv
// Turns debounced active-low button levels into SHORT/LONG/REPEAT events.
// One key is owned at a time; events leave through a one-entry valid/ready register.
module key_event_ctrl #(
  parameter int NUM_KEYS = 4,
  parameter int LONG_CYC = 50_000_000,
  parameter int RPT_CYC  = 10_000_000,
  parameter int CNT_W    = 26,
  localparam int KEY_W   = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_lvl,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_key,
  output logic [1:0]          evt_type,
  output logic                evt_drop,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    RPT
  } state_t;

  localparam logic [1:0] T_SHORT  = 2'b00;
  localparam logic [1:0] T_LONG   = 2'b01;
  localparam logic [1:0] T_REPEAT = 2'b10;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [KEY_W-1:0]    sel;
  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] press;
  logic [KEY_W-1:0]    first;
  logic                rel;
  logic                long_hit;
  logic                rpt_hit;
  logic                emit;
  logic [1:0]          etype;

  assign press    = key_q & ~key_lvl;
  assign rel      = key_lvl[sel];
  assign long_hit = (cnt == CNT_W'(LONG_CYC - 1));
  assign rpt_hit  = (cnt == CNT_W'(RPT_CYC - 1));
  assign busy     = (state != IDLE);

  // Lowest pressed index wins when several keys fall together.
  always_comb begin
    first = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (press[k]) first = KEY_W'(k);
    end
  end

  // Release takes priority over timer expiry.
  always_comb begin
    emit  = 1'b0;
    etype = T_SHORT;
    unique case (state)
      HELD: begin
        if (rel) begin
          emit  = 1'b1;
          etype = T_SHORT;
        end else if (long_hit) begin
          emit  = 1'b1;
          etype = T_LONG;
        end
      end
      RPT: begin
        if (!rel && rpt_hit) begin
          emit  = 1'b1;
          etype = T_REPEAT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '1;
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= T_SHORT;
      evt_drop  <= 1'b0;
    end else begin
      key_q    <= key_lvl;
      evt_drop <= 1'b0;

      if (emit) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_key   <= sel;
          evt_type  <= etype;
        end else begin
          evt_drop <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (|press) begin
            sel   <= first;
            cnt   <= '0;
            state <= HELD;
          end
        end
        HELD: begin
          if (rel) begin
            state <= IDLE;
          end else if (long_hit) begin
            cnt   <= '0;
            state <= RPT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RPT: begin
          if (rel) begin
            state <= IDLE;
          end else if (rpt_hit) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed cycle-vector bench for key_event_ctrl (LONG=8, RPT=4, 4 keys).
// Inputs change on the falling edge; outputs are compared on the next falling edge.
module tb_key_event_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_lvl;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       evt_drop;
  logic       busy;

  int checks;
  int failures;

  key_event_ctrl #(
    .NUM_KEYS(4),
    .LONG_CYC(8),
    .RPT_CYC (4),
    .CNT_W   (26)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_lvl  (key_lvl),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_type (evt_type),
    .evt_drop (evt_drop),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] kl;
    logic       rdy;
    logic       v;
    logic [1:0] k;
    logic [1:0] t;
    logic       d;
    logic       b;
  } vec_t;

  vec_t vq[$];

  task automatic addn(input int n, input string nm, input logic [3:0] kl,
                      input logic rdy, input logic v, input logic [1:0] k,
                      input logic [1:0] t, input logic d, input logic b);
    vec_t e;
    e.nm = nm; e.kl = kl; e.rdy = rdy; e.v = v;
    e.k = k; e.t = t; e.d = d; e.b = b;
    for (int i = 0; i < n; i++) vq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input string nm, input logic [3:0] kl, input logic rdy,
                      input logic v, input logic [1:0] k, input logic [1:0] t,
                      input logic d, input logic b);
    key_lvl   = kl;
    evt_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".valid"}, 32'(evt_valid), 32'(v));
    chk({nm, ".drop"}, 32'(evt_drop), 32'(d));
    chk({nm, ".busy"}, 32'(busy), 32'(b));
    if (v) begin
      chk({nm, ".key"}, 32'(evt_key), 32'(k));
      chk({nm, ".type"}, 32'(evt_type), 32'(t));
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    key_lvl   = 4'b1111;
    evt_ready = 1'b1;

    // short press on key 1
    addn(2, "s1_idle",  4'b1111, 1, 0, 0, 0, 0, 0);
    addn(3, "s1_hold",  4'b1101, 1, 0, 0, 0, 0, 1);
    addn(1, "s1_short", 4'b1111, 1, 1, 1, 0, 0, 0);
    addn(2, "s1_clear", 4'b1111, 1, 0, 0, 0, 0, 0);
    // long + repeats on key 0, release collides with expiry
    addn(8, "s2_hold",  4'b1110, 1, 0, 0, 0, 0, 1);
    addn(1, "s2_long",  4'b1110, 1, 1, 0, 1, 0, 1);
    addn(3, "s2_wait1", 4'b1110, 1, 0, 0, 0, 0, 1);
    addn(1, "s2_rpt1",  4'b1110, 1, 1, 0, 2, 0, 1);
    addn(3, "s2_wait2", 4'b1110, 1, 0, 0, 0, 0, 1);
    addn(1, "s2_rpt2",  4'b1110, 1, 1, 0, 2, 0, 1);
    addn(3, "s2_wait3", 4'b1110, 1, 0, 0, 0, 0, 1);
    addn(1, "s2_rel",   4'b1111, 1, 0, 0, 0, 0, 0);
    addn(1, "s2_idle",  4'b1111, 1, 0, 0, 0, 0, 0);
    // keys 2 and 3 together, lowest wins, key 3 ignored
    addn(3, "s3_hold",  4'b0011, 1, 0, 0, 0, 0, 1);
    addn(2, "s3_k3up",  4'b1011, 1, 0, 0, 0, 0, 1);
    addn(1, "s3_short", 4'b1111, 1, 1, 2, 0, 0, 0);
    addn(1, "s3_clear", 4'b1111, 1, 0, 0, 0, 0, 0);
    // backpressure: LONG held, REPEATs dropped
    addn(8, "s4_hold",   4'b1110, 0, 0, 0, 0, 0, 1);
    addn(4, "s4_long",   4'b1110, 0, 1, 0, 1, 0, 1);
    addn(1, "s4_drop1",  4'b1110, 0, 1, 0, 1, 1, 1);
    addn(3, "s4_stable", 4'b1110, 0, 1, 0, 1, 0, 1);
    addn(1, "s4_drop2",  4'b1110, 0, 1, 0, 1, 1, 1);
    addn(1, "s4_rel",    4'b1111, 0, 1, 0, 1, 0, 0);
    addn(1, "s4_xfer",   4'b1111, 1, 0, 0, 0, 0, 0);
    addn(1, "s4_idle",   4'b1111, 1, 0, 0, 0, 0, 0);
    // release exactly at cnt=7 gives SHORT
    addn(8, "s5_hold",  4'b1101, 1, 0, 0, 0, 0, 1);
    addn(1, "s5_short", 4'b1111, 1, 1, 1, 0, 0, 0);
    addn(1, "s5_idle",  4'b1111, 1, 0, 0, 0, 0, 0);

    #1;
    chk("rst.valid", 32'(evt_valid), 0);
    chk("rst.key",   32'(evt_key),   0);
    chk("rst.type",  32'(evt_type),  0);
    chk("rst.drop",  32'(evt_drop),  0);
    chk("rst.busy",  32'(busy),      0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].nm, vq[i].kl, vq[i].rdy, vq[i].v, vq[i].k,
           vq[i].t, vq[i].d, vq[i].b);
    end

    // reset in RPT with a pending LONG and key 0 still low
    for (int i = 0; i < 8; i++) step("s6_hold", 4'b1110, 0, 0, 0, 0, 0, 1);
    step("s6_long", 4'b1110, 0, 1, 0, 1, 0, 1);
    step("s6_rpt",  4'b1110, 0, 1, 0, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst.valid", 32'(evt_valid), 0);
    chk("s6_rst.busy",  32'(busy),      0);
    chk("s6_rst.type",  32'(evt_type),  0);
    step("s6_inrst", 4'b1110, 1, 0, 0, 0, 0, 0);
    step("s6_inrst", 4'b1110, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step("s6_repress", 4'b1110, 1, 0, 0, 0, 0, 1);
    step("s6_long2", 4'b1110, 1, 1, 0, 1, 0, 1);
    step("s6_clr",   4'b1110, 1, 0, 0, 0, 0, 1);
    step("s6_rel",   4'b1111, 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
